// File: rtl/pipe_arb_pkg.sv
// Shared types and the round-robin helper for the pipe endpoint arbiters.
package pipe_arb_pkg;

    localparam int SRC_IDX_W = 3;
    localparam int MAX_SRC   = 1 << SRC_IDX_W;

    typedef enum logic [1:0] {IDLE, ARB, READY, XFER} arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [SRC_IDX_W-1:0] idx;
    } rr_pick_t;

    // First eligible index at or after ptr, wrapping modulo n_src. Walking k
    // downwards lets the smallest rotation distance win without a found flag.
    function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] eligible,
                                         input logic [SRC_IDX_W-1:0] ptr,
                                         input int n_src);
        rr_pick_t pick;
        int       j;
        pick = '0;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < n_src) begin
                j = int'(ptr) + k;
                if (j >= n_src) j = j - n_src;
                if (eligible[j[SRC_IDX_W-1:0]]) begin
                    pick.valid = 1'b1;
                    pick.idx   = SRC_IDX_W'(j);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate / find-first / unrotate picker over N_SRC requesters.
module rr_priority_pick
    import pipe_arb_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]     req,
    input  logic [SRC_IDX_W-1:0] ptr,
    output logic                 grant_valid,
    output logic [SRC_IDX_W-1:0] grant_idx
);

    rr_pick_t pick;

    assign pick        = rr_pick(MAX_SRC'(req), ptr, N_SRC);
    assign grant_valid = pick.valid;
    assign grant_idx   = pick.idx;

endmodule

// File: rtl/pipe_out_arbiter.sv
// Shares one block-throttled pipe-out endpoint between N_SRC FWFT source FIFOs,
// granting whole blocks in round-robin order.
module pipe_out_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 16,
    parameter int BLOCK_LEN = 256,
    parameter int CNT_W     = 11
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [N_SRC*CNT_W-1:0]  src_count,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_rd,
    input  logic                    ep_read,
    input  logic                    ep_blockstrobe,
    output logic                    ep_ready,
    output logic [DATA_W-1:0]       ep_datain,
    output logic [2:0]              cur_src,
    output logic                    underrun,
    output logic [15:0]             blocks_sent
);

    localparam int                WCNT_W    = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BLOCK_LEN - 1);

    arb_state_e           state_q, state_d;
    logic [SRC_IDX_W-1:0] ptr_q, ptr_d;
    logic [SRC_IDX_W-1:0] cur_src_q, cur_src_d;
    logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                 ep_ready_q, ep_ready_d;
    logic                 underrun_q, underrun_d;
    logic [15:0]          blocks_sent_q, blocks_sent_d;

    logic [N_SRC-1:0]     eligible;
    logic                 pick_valid;
    logic [SRC_IDX_W-1:0] pick_idx;
    logic [DATA_W-1:0]    sel_data;

    // Both sides widened to 32 bits so the compare is unsigned at full CNT_W width.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = 32'(src_count[i*CNT_W +: CNT_W]) >= 32'(BLOCK_LEN);
        end
    end

    rr_priority_pick #(.N_SRC(N_SRC)) u_pick (
        .req         (eligible),
        .ptr         (ptr_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    // NOTE: every flop, including the counters, gets a defined reset value;
    // a mid-block reset simply abandons the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cur_src_q     <= '0;
            word_cnt_q    <= '0;
            ep_ready_q    <= 1'b0;
            underrun_q    <= 1'b0;
            blocks_sent_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cur_src_q     <= cur_src_d;
            word_cnt_q    <= word_cnt_d;
            ep_ready_q    <= ep_ready_d;
            underrun_q    <= underrun_d;
            blocks_sent_q <= blocks_sent_d;
        end
    end

    always_comb begin
        // NOTE: hold defaults first so no path through the case leaves a latch.
        state_d       = state_q;
        ptr_d         = ptr_q;
        cur_src_d     = cur_src_q;
        word_cnt_d    = word_cnt_q;
        ep_ready_d    = ep_ready_q;
        blocks_sent_d = blocks_sent_q;
        underrun_d    = underrun_q | (ep_read & (state_q != XFER));

        case (state_q)
            IDLE: begin
                if (enable) state_d = ARB;
            end
            ARB: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (pick_valid) begin
                    cur_src_d  = pick_idx;
                    ep_ready_d = 1'b1;
                    state_d    = READY;
                end
            end
            // Enable is deliberately ignored here: an offered block is honoured.
            READY: begin
                if (ep_blockstrobe) begin
                    word_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (ep_read) begin
                    if (word_cnt_q == LAST_WORD) begin
                        ep_ready_d    = 1'b0;
                        blocks_sent_d = blocks_sent_q + 16'd1;
                        ptr_d         = (cur_src_q == SRC_IDX_W'(N_SRC - 1)) ? '0
                                                                             : cur_src_q + 1'b1;
                        state_d       = enable ? ARB : IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cur_src_q == SRC_IDX_W'(i)) sel_data = src_data[i*DATA_W +: DATA_W];
        end
    end

    // Stray reads outside XFER are neither forwarded nor given data.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_rd[i] = (state_q == XFER) && (cur_src_q == SRC_IDX_W'(i)) && ep_read;
        end
        ep_datain = '0;
        if (state_q == XFER || (state_q == READY && !ep_read)) ep_datain = sel_data;
    end

    assign ep_ready    = ep_ready_q;
    assign cur_src     = cur_src_q;
    assign underrun    = underrun_q;
    assign blocks_sent = blocks_sent_q;

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// Self-checking bench for pipe_out_arbiter: directed vectors, block sequences and
// randomized traffic against a block-level reference model.
module tb_pipe_out_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BL = 256;
    localparam int CW = 11;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic            ep_read;
    logic            ep_blockstrobe;
    logic [N*CW-1:0] src_count;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_rd;
    logic            ep_ready;
    logic [DW-1:0]   ep_datain;
    logic [2:0]      cur_src;
    logic            underrun;
    logic [15:0]     blocks_sent;

    logic [CW-1:0]   cnt [N];
    logic [DW-1:0]   dat [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_count[i*CW +: CW] = cnt[i];
            src_data[i*DW +: DW]  = dat[i];
        end
    end

    pipe_out_arbiter #(.N_SRC(N), .DATA_W(DW), .BLOCK_LEN(BL), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .src_count      (src_count),
        .src_data       (src_data),
        .src_rd         (src_rd),
        .ep_read        (ep_read),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_ready       (ep_ready),
        .ep_datain      (ep_datain),
        .cur_src        (cur_src),
        .underrun       (underrun),
        .blocks_sent    (blocks_sent)
    );

    // Block-level reference: is the arbiter hunting for a block, offering one,
    // or moving one; which source; how many words moved; where the hunt starts.
    typedef struct {
        bit seek;
        bit offer;
        bit move;
        int src;
        int first;
        int words;
        bit err;
        int sent;
    } model_t;

    model_t m = '{default: 0};

    function automatic model_t step(model_t s);
        model_t n;
        bit     found;
        int     idx;
        n = s;
        if (ep_read && !s.move) n.err = 1'b1;
        if (s.move) begin
            if (ep_read) begin
                n.words = s.words + 1;
                if (n.words == BL) begin
                    n.move  = 1'b0;
                    n.sent  = (s.sent + 1) % 65536;
                    n.first = (s.src + 1) % N;
                    n.seek  = enable;
                end
            end
        end else if (s.offer) begin
            if (ep_blockstrobe) begin
                n.offer = 1'b0;
                n.move  = 1'b1;
                n.words = 0;
            end
        end else if (s.seek) begin
            if (!enable) begin
                n.seek = 1'b0;
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (s.first + k) % N;
                    if (!found && int'(cnt[idx]) >= BL) begin
                        found   = 1'b1;
                        n.src   = idx;
                        n.offer = 1'b1;
                        n.seek  = 1'b0;
                    end
                end
            end
        end else if (enable) begin
            n.seek = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '{default: 0};
        else          m <= step(m);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        enable         = 1'b0;
        ep_read        = 1'b0;
        ep_blockstrobe = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        while (ep_ready !== 1'b1 && waited < 64) begin
            next_cycle();
            @(negedge clk);
            waited++;
        end
        check("wait_ready_timeout", 32'(ep_ready === 1'b1), 32'd1);
    endtask

    // Strobe, then BL reads with a known ramp on the selected source.
    task automatic xfer_block(input int src, input int drop_at, input string tag);
        int            errs;
        logic [DW-1:0] want;
        errs = 0;
        next_cycle();
        ep_blockstrobe = 1'b1;
        @(negedge clk);
        next_cycle();
        ep_blockstrobe = 1'b0;
        for (int k = 0; k < BL; k++) begin
            if (k > 0) next_cycle();
            want     = 16'(k);
            ep_read  = 1'b1;
            dat[src] = want;
            if (k == drop_at) enable = 1'b0;
            @(negedge clk);
            if (ep_datain !== want) errs++;
            if (src_rd !== (4'b0001 << src)) errs++;
            if (ep_ready !== 1'b1) errs++;
        end
        check({tag, "_word_errs"}, 32'(errs), 32'd0);
        next_cycle();
        ep_read = 1'b0;
        @(negedge clk);
        check({tag, "_ready_low_after"}, 32'(ep_ready), 32'd0);
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0]  e_rd;
        logic [DW-1:0] e_dat;
        e_rd  = (m.move && ep_read) ? (4'b0001 << m.src) : '0;
        e_dat = (m.move || (m.offer && !ep_read)) ? dat[m.src] : '0;
        check({tag, "_ready"},  32'(ep_ready),    32'(m.offer || m.move));
        check({tag, "_cur"},    32'(cur_src),     32'(m.src));
        check({tag, "_rd"},     32'(src_rd),      32'(e_rd));
        check({tag, "_data"},   32'(ep_datain),   32'(e_dat));
        check({tag, "_under"},  32'(underrun),    32'(m.err));
        check({tag, "_blocks"}, 32'(blocks_sent), 32'(m.sent));
    endtask

    typedef struct {
        bit            en;
        bit            stb;
        bit            rd;
        bit            exp_ready;
        int            exp_cur;
        logic [N-1:0]  exp_rd;
        logic [DW-1:0] exp_dat;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   waited;
        int   highs;

        for (int i = 0; i < N; i++) dat[i] = 16'h1234 + 16'(i);

        // Reset values while reset_n is held low.
        reset_n        = 1'b0;
        enable         = 1'b0;
        ep_read        = 1'b0;
        ep_blockstrobe = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = '0;
        #3;
        check("rst_ready",  32'(ep_ready),    32'd0);
        check("rst_rd",     32'(src_rd),      32'd0);
        check("rst_cur",    32'(cur_src),     32'd0);
        check("rst_under",  32'(underrun),    32'd0);
        check("rst_blocks", 32'(blocks_sent), 32'd0);
        check("rst_data",   32'(ep_datain),   32'd0);

        // First grant: only source 2 holds a block.
        do_reset();
        cnt[2] = 11'd300;
        dat[2] = 16'hA5A5;
        vecs[0] = '{en: 1, stb: 0, rd: 0, exp_ready: 0, exp_cur: 0, exp_rd: '0, exp_dat: '0};
        vecs[1] = '{en: 1, stb: 0, rd: 0, exp_ready: 0, exp_cur: 0, exp_rd: '0, exp_dat: '0};
        vecs[2] = '{en: 1, stb: 0, rd: 0, exp_ready: 1, exp_cur: 2, exp_rd: '0, exp_dat: 16'hA5A5};
        vecs[3] = '{en: 1, stb: 0, rd: 0, exp_ready: 1, exp_cur: 2, exp_rd: '0, exp_dat: 16'hA5A5};
        for (int v = 0; v < 4; v++) begin
            next_cycle();
            enable         = vecs[v].en;
            ep_blockstrobe = vecs[v].stb;
            ep_read        = vecs[v].rd;
            @(negedge clk);
            check($sformatf("vec%0d_ready", v), 32'(ep_ready),  32'(vecs[v].exp_ready));
            check($sformatf("vec%0d_cur", v),   32'(cur_src),   32'(vecs[v].exp_cur));
            check($sformatf("vec%0d_rd", v),    32'(src_rd),    32'(vecs[v].exp_rd));
            check($sformatf("vec%0d_data", v),  32'(ep_datain), 32'(vecs[v].exp_dat));
        end
        xfer_block(2, -1, "first");
        check("first_blocks", 32'(blocks_sent), 32'd1);

        // Back-to-back blocks, all sources eligible.
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 11'd512;
        enable = 1'b1;
        for (int b = 0; b < 8; b++) begin
            wait_ready(waited);
            if (b > 0) check($sformatf("b2b%0d_gap", b), 32'(waited), 32'd1);
            check($sformatf("b2b%0d_cur", b), 32'(cur_src), 32'(b % N));
            xfer_block(b % N, -1, $sformatf("b2b%0d", b));
        end
        check("b2b_blocks", 32'(blocks_sent), 32'd8);

        // Stray reads in IDLE and READY.
        do_reset();
        for (int i = 0; i < N; i++) dat[i] = 16'h7E00 + 16'(i);
        next_cycle();
        ep_read = 1'b1;
        @(negedge clk);
        check("idle_stray_rd", 32'(src_rd), 32'd0);
        next_cycle();
        ep_read = 1'b0;
        @(negedge clk);
        check("idle_stray_under", 32'(underrun), 32'd1);
        cnt[1] = 11'd512;
        enable = 1'b1;
        wait_ready(waited);
        next_cycle();
        ep_read = 1'b1;
        @(negedge clk);
        check("ready_stray_rd",    32'(src_rd),    32'd0);
        check("ready_stray_data",  32'(ep_datain), 32'd0);
        check("ready_stray_ready", 32'(ep_ready),  32'd1);
        next_cycle();
        ep_read = 1'b0;
        @(negedge clk);
        check("ready_stray_cur", 32'(cur_src), 32'd1);
        xfer_block(1, -1, "after_stray");
        check("after_stray_blocks", 32'(blocks_sent), 32'd1);
        check("after_stray_under",  32'(underrun),    32'd1);

        // Source one word short of a block never gets offered.
        do_reset();
        cnt[1] = 11'd255;
        enable = 1'b1;
        highs  = 0;
        for (int c = 0; c < 1000; c++) begin
            next_cycle();
            @(negedge clk);
            if (ep_ready !== 1'b0) highs++;
        end
        check("starve_highs", 32'(highs), 32'd0);
        next_cycle();
        cnt[1] = 11'd256;
        @(negedge clk);
        check("starve_arb_cycle", 32'(ep_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        check("starve_ready", 32'(ep_ready), 32'd1);
        check("starve_cur",   32'(cur_src),  32'd1);

        // Enable dropped mid-block: block completes, then idle.
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 11'd512;
        enable = 1'b1;
        wait_ready(waited);
        xfer_block(0, 100, "drop");
        highs = 0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            if (ep_ready !== 1'b0) highs++;
        end
        check("drop_stays_idle", 32'(highs),       32'd0);
        check("drop_blocks",     32'(blocks_sent), 32'd1);

        // Reset pulse mid-block returns every output to its reset value at once.
        next_cycle();
        ep_read = 1'b1;
        next_cycle();
        ep_read = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = '0;
        cnt[3] = 11'd512;
        enable = 1'b1;
        wait_ready(waited);
        check("mid_cur_before", 32'(cur_src), 32'd3);
        next_cycle();
        ep_blockstrobe = 1'b1;
        next_cycle();
        ep_blockstrobe = 1'b0;
        ep_read        = 1'b1;
        repeat (50) next_cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready",  32'(ep_ready),    32'd0);
        check("mid_rst_rd",     32'(src_rd),      32'd0);
        check("mid_rst_cur",    32'(cur_src),     32'd0);
        check("mid_rst_under",  32'(underrun),    32'd0);
        check("mid_rst_blocks", 32'(blocks_sent), 32'd0);
        check("mid_rst_data",   32'(ep_datain),   32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            enable         = ($urandom_range(0, 99) < 97);
            ep_blockstrobe = ($urandom_range(0, 99) < 30);
            ep_read        = ($urandom_range(0, 99) < 75);
            for (int i = 0; i < N; i++) begin
                dat[i] = 16'($urandom);
                if ($urandom_range(0, 9) == 0) cnt[i] = 11'($urandom_range(0, 511));
            end
            @(negedge clk);
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_out_arbiter.md
Name: pipe_out_arbiter

Overview:
- Shares one block-throttled pipe-out endpoint between N_SRC first-word-fall-through (FWFT) source FIFOs.
- Selects one source per block, using round-robin order. The arbiter only makes a source eligible once it holds at least one full block.
- Drives the endpoint's ready flag and steers the endpoint's read strobes and data to the selected source.
- Sits between the per-channel capture FIFOs and the pipe-out endpoint, in the host-interface clock domain.

Parameters:
- N_SRC, 4, number of requesting source FIFOs (2..8).
- DATA_W, 16, endpoint and FIFO data width.
- BLOCK_LEN, 256, words per block transfer (power of two, >=2).
- CNT_W, 11, width of each source FIFO fill-count input.

Ports:
- clk  in  1  endpoint clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  arbitration enable, sourced from a host wire-in bit.
- src_count  in  N_SRC*CNT_W  per-source FIFO fill level; source i occupies slice [i*CNT_W +: CNT_W].
- src_data  in  N_SRC*DATA_W  per-source FWFT head word.
- src_rd  out  N_SRC  per-source read strobe, one-hot or zero.
- ep_read  in  1  endpoint read strobe.
- ep_blockstrobe  in  1  endpoint block-start pulse.
- ep_ready  out  1  a full block is available on the selected source.
- ep_datain  out  DATA_W  data to the endpoint.
- cur_src  out  3  index of the selected source.
- underrun  out  1  sticky error flag.
- blocks_sent  out  16  wrapping count of completed blocks.

Behaviour:
- Reset values (async, applied while reset_n=0):
  - state=IDLE, ptr=0, cur_src=0, word_cnt=0.
  - ep_ready=0, src_rd=0, underrun=0, blocks_sent=0.
- A reset mid-block abandons the block; no partial-block recovery is attempted.
- States:
  - IDLE: go to ARB when enable=1.
  - ARB: single cycle. Scan sources ptr, ptr+1, ... (mod N_SRC) for the first i with src_count[i] >= BLOCK_LEN.
    - If found: cur_src<=i, ep_ready<=1, go to READY.
    - If none found: stay in ARB with ep_ready=0.
    - If enable=0: go to IDLE.
  - READY: ep_ready held at 1 and cur_src frozen.
    - ep_blockstrobe=1 -> go to XFER, word_cnt<=0.
    - If enable drops while in READY, stay in READY; the offered block is still honoured.
  - XFER: each cycle with ep_read=1, word_cnt increments.
    - When ep_read=1 and word_cnt==BLOCK_LEN-1: ep_ready<=0, blocks_sent increments (wraps at 2^16), ptr<=cur_src+1 (mod N_SRC), go to ARB if enable=1, else IDLE.
    - ep_blockstrobe in XFER is ignored.
- Datapath (combinational):
  - src_rd[cur_src] = ep_read when state==XFER; all other src_rd bits are 0.
  - ep_datain = src_data[cur_src] when state is READY or XFER, else 0. This gives zero-latency FWFT reads.
- ep_ready timing: registered. It is low for at least one cycle (the ARB cycle) between consecutive blocks.
- Underrun:
  - ep_read=1 outside XFER sets underrun.
  - The stray read is not forwarded: src_rd=0 and ep_datain=0.
  - underrun clears only on reset.
- Fairness: a source that just sent a block has lowest priority in the next ARB. A continuously eligible source is served at least once every N_SRC blocks.
- Fill-level compare: src_count is compared unsigned at full CNT_W width; BLOCK_LEN is zero-extended.
- FIFO contract: FIFO depth must be >= BLOCK_LEN. src_count of the selected source is not rechecked during XFER.

Decomposition:
- Package pipe_arb_pkg holds:
  - state enum {IDLE, ARB, READY, XFER};
  - the cur_src index width constant;
  - the helper function rr_pick(eligible mask, ptr) -> index plus valid.
- Natural sub-module: rr_priority_pick. It is a combinational rotate, find-first and unrotate over N_SRC, reused by the future pipe-in distributor.

Test Plan:
- Reset, then enable=1, src_count={0,0,300,0} -> ARB picks source 2; ep_ready=1 two cycles after enable; cur_src=2.
- Blockstrobe then 256 ep_read with src_data[2] ramping 0..255 -> ep_datain matches every cycle; src_rd=4'b0100 on each read; ep_ready=0 the cycle after read 256; blocks_sent=1.
- All src_count=512, 8 back-to-back blocks -> cur_src order 0,1,2,3,0,1,2,3; ep_ready low exactly one cycle between blocks.
- ep_read pulse in IDLE and in READY -> underrun=1 and stays 1; src_rd=0; word_cnt unchanged; a later block still transfers 256 words.
- src_count[1]=255 only -> ep_ready remains 0 for 1000 cycles; raise to 256 -> ep_ready=1 after the ARB cycle with cur_src=1.
- enable dropped at word 100 of a block -> block completes (256 reads), then state=IDLE and ep_ready=0; reset_n pulse mid-block -> all outputs at reset values immediately.
